// File: rtl/cpu_lsu.sv
// Load/store unit: one request at a time over valid/ready, req/ack bus cycles with
// wait states, optional two-beat split of misaligned accesses, and per-beat timeout.
module cpu_lsu #(
    parameter int BUS_WORD_ADDR_WIDTH = 16,
    parameter int ALLOW_MISALIGNED    = 1,
    parameter int TIMEOUT_CYCLES      = 255
) (
    input  logic                           i_Clk,
    input  logic                           i_Rst,
    input  logic                           i_Req_Valid,
    output logic                           o_Req_Ready,
    input  logic [31:0]                    i_Req_Addr,
    input  logic                           i_Req_WE,
    input  logic [2:0]                     i_Req_Mode,
    input  logic [31:0]                    i_Req_WD,
    output logic                           o_Rsp_Valid,
    output logic [31:0]                    o_Rsp_RD,
    output logic                           o_Rsp_Err,
    output logic                           o_Bus_Req,
    input  logic                           i_Bus_Ack,
    output logic [BUS_WORD_ADDR_WIDTH-1:0] o_Bus_Addr,
    output logic                           o_Bus_WE,
    output logic [3:0]                     o_Bus_ByteEn,
    output logic [31:0]                    o_Bus_WD,
    input  logic [31:0]                    i_Bus_RD
);

    localparam int AW = BUS_WORD_ADDR_WIDTH;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, RESP} state_t;

    state_t state, state_next;

    logic [AW-1:0] waddr_q;
    logic [1:0]    off_q;
    logic [2:0]    mode_q;
    logic          we_q;
    logic [31:0]   wd_q;
    logic          split_q;
    logic [31:0]   rd_lo_q;
    logic [TW-1:0] tcnt_q;
    logic [31:0]   rsp_rd_q;
    logic          rsp_err_q;

    logic        accept, mode_bad, addr_bad, misaligned, req_err, beat, timeout_hit;
    logic [63:0] rd_raw;
    logic [31:0] rd_sh, rd_ext;
    logic [3:0]  be_base;
    logic [7:0]  be_wide;
    logic [63:0] wd_wide;

    assign accept     = (state == IDLE) && i_Req_Valid;
    assign mode_bad   = (i_Req_Mode[1:0] == 2'b11) || (i_Req_Mode[2] && (i_Req_Mode[1] || i_Req_WE));
    assign addr_bad   = (i_Req_Addr >> (AW + 2)) != 32'd0;
    assign misaligned = ((i_Req_Mode[1:0] == 2'b01) && (i_Req_Addr[1:0] == 2'b11)) ||
                        ((i_Req_Mode[1:0] == 2'b10) && (i_Req_Addr[1:0] != 2'b00));
    assign req_err    = mode_bad || addr_bad || (misaligned && (ALLOW_MISALIGNED == 0));
    assign beat       = (state == BEAT1) || (state == BEAT2);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && beat && !i_Bus_Ack && (tcnt_q == TO_LAST);

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = req_err ? RESP : BEAT1;
            BEAT1: begin
                if (i_Bus_Ack)        state_next = split_q ? BEAT2 : RESP;
                else if (timeout_hit) state_next = RESP;
            end
            BEAT2: if (i_Bus_Ack || timeout_hit) state_next = RESP;
            RESP:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // A split access is the 64-bit window {next word, this word} viewed from the byte offset.
    always_comb begin
        rd_raw = (state == BEAT2) ? {i_Bus_RD, rd_lo_q} : {32'd0, i_Bus_RD};
        rd_sh  = 32'(rd_raw >> {off_q, 3'b000});
        case (mode_q)
            3'b000:  rd_ext = {{24{rd_sh[7]}}, rd_sh[7:0]};
            3'b001:  rd_ext = {{16{rd_sh[15]}}, rd_sh[15:0]};
            3'b100:  rd_ext = {24'd0, rd_sh[7:0]};
            3'b101:  rd_ext = {16'd0, rd_sh[15:0]};
            default: rd_ext = rd_sh;
        endcase
        case (mode_q[1:0])
            2'b00:   be_base = 4'b0001;
            2'b01:   be_base = 4'b0011;
            default: be_base = 4'b1111;
        endcase
        be_wide = {4'd0, be_base} << off_q;
        wd_wide = {32'd0, wd_q} << {off_q, 3'b000};
    end

    always_comb begin
        o_Req_Ready  = (state == IDLE);
        o_Rsp_Valid  = (state == RESP);
        o_Rsp_RD     = rsp_rd_q;
        o_Rsp_Err    = rsp_err_q;
        o_Bus_Req    = 1'b0;
        o_Bus_Addr   = '0;
        o_Bus_WE     = 1'b0;
        o_Bus_ByteEn = '0;
        o_Bus_WD     = '0;
        case (state)
            BEAT1: begin
                o_Bus_Req    = 1'b1;
                o_Bus_Addr   = waddr_q;
                o_Bus_WE     = we_q;
                o_Bus_ByteEn = be_wide[3:0];
                o_Bus_WD     = wd_wide[31:0];
            end
            BEAT2: begin
                o_Bus_Req    = 1'b1;
                o_Bus_Addr   = waddr_q + AW'(1);
                o_Bus_WE     = we_q;
                o_Bus_ByteEn = be_wide[7:4];
                o_Bus_WD     = wd_wide[63:32];
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Rst) begin
        if (!i_Rst) begin
            waddr_q   <= '0;
            off_q     <= '0;
            mode_q    <= '0;
            we_q      <= 1'b0;
            wd_q      <= '0;
            split_q   <= 1'b0;
            rd_lo_q   <= '0;
            tcnt_q    <= '0;
            rsp_rd_q  <= '0;
            rsp_err_q <= 1'b0;
        end else begin
            if (accept) begin
                waddr_q <= i_Req_Addr[AW+1:2];
                off_q   <= i_Req_Addr[1:0];
                mode_q  <= i_Req_Mode;
                we_q    <= i_Req_WE;
                wd_q    <= i_Req_WD;
                split_q <= misaligned;
            end
            if (state != state_next) tcnt_q <= '0;
            else if (beat)           tcnt_q <= tcnt_q + TW'(1);
            if ((state == BEAT1) && i_Bus_Ack) rd_lo_q <= i_Bus_RD;
            if ((state_next == RESP) && (state != RESP)) begin
                if ((state == IDLE) || !i_Bus_Ack) begin
                    rsp_err_q <= 1'b1;
                    rsp_rd_q  <= '0;
                end else begin
                    rsp_err_q <= 1'b0;
                    rsp_rd_q  <= we_q ? 32'd0 : rd_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_lsu.sv
// Directed bench for cpu_lsu: negedge-driven requests, a wait-state bus responder
// that records each beat, and hand-computed expectations.
module tb_cpu_lsu;

    logic        clk, rst_n;
    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wd;
    logic [2:0]  req_mode;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rd;
    logic        bus_req, bus_ack, bus_we;
    logic [15:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wd, bus_rd;

    int tests_run = 0;
    int tests_failed = 0;

    int          waits, wcnt, nbeats, req_cyc;
    bit          no_ack;
    logic [31:0] rdw [0:1];
    logic [15:0] b_addr [0:3];
    logic [3:0]  b_be [0:3];
    logic [31:0] b_wd [0:3];
    logic        b_we [0:3];

    cpu_lsu #(
        .BUS_WORD_ADDR_WIDTH(16),
        .ALLOW_MISALIGNED(1),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .i_Clk(clk),
        .i_Rst(rst_n),
        .i_Req_Valid(req_valid),
        .o_Req_Ready(req_ready),
        .i_Req_Addr(req_addr),
        .i_Req_WE(req_we),
        .i_Req_Mode(req_mode),
        .i_Req_WD(req_wd),
        .o_Rsp_Valid(rsp_valid),
        .o_Rsp_RD(rsp_rd),
        .o_Rsp_Err(rsp_err),
        .o_Bus_Req(bus_req),
        .i_Bus_Ack(bus_ack),
        .o_Bus_Addr(bus_addr),
        .o_Bus_WE(bus_we),
        .o_Bus_ByteEn(bus_be),
        .o_Bus_WD(bus_wd),
        .i_Bus_RD(bus_rd)
    );

    always #5 clk = ~clk;

    // Responder: acks a beat after `waits` idle cycles and logs what the DUT presented.
    always @(negedge clk) begin
        if (bus_req) begin
            req_cyc++;
            if (!no_ack && wcnt >= waits) begin
                bus_ack = 1'b1;
                bus_rd  = rdw[(nbeats == 0) ? 0 : 1];
                if (nbeats < 4) begin
                    b_addr[nbeats] = bus_addr;
                    b_be[nbeats]   = bus_be;
                    b_wd[nbeats]   = bus_wd;
                    b_we[nbeats]   = bus_we;
                end
                nbeats++;
                wcnt = 0;
            end else begin
                bus_ack = 1'b0;
                wcnt++;
            end
        end else begin
            bus_ack = 1'b0;
            wcnt    = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] addr, input logic we,
                          input logic [2:0] mode, input logic [31:0] wd, input int w,
                          input bit na, input int exp_lat, input logic [31:0] exp_rd,
                          input logic exp_err);
        int          lat;
        logic [31:0] rd;
        logic        err;
        bit          seen;
        lat = 0; rd = '0; err = 1'b0; seen = 0;
        nbeats = 0; req_cyc = 0; waits = w; no_ack = na;
        check({tag, "_ready"}, req_ready, 1);
        req_valid = 1'b1; req_addr = addr; req_we = we; req_mode = mode; req_wd = wd;
        @(negedge clk);
        req_valid = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            if (rsp_valid) begin
                seen = 1; lat = c; rd = rsp_rd; err = rsp_err;
            end else begin
                @(negedge clk);
            end
        end
        check({tag, "_rsp_seen"}, seen, 1);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rd"}, rd, exp_rd);
        check({tag, "_err"}, err, exp_err);
        @(negedge clk);
        check({tag, "_pulse"}, rsp_valid, 0);
        check({tag, "_hold_rd"}, rsp_rd, exp_rd);
        check({tag, "_hold_err"}, rsp_err, exp_err);
        no_ack = 0;
    endtask

    initial begin
        bit seen;
        clk = 0; rst_n = 0; req_valid = 0; req_addr = '0; req_we = 0; req_mode = '0; req_wd = '0;
        bus_ack = 0; bus_rd = '0; waits = 0; wcnt = 0; nbeats = 0; req_cyc = 0; no_ack = 0;
        rdw[0] = '0; rdw[1] = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 1);
        check("rst_bus_req", bus_req, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rd", rsp_rd, 0);
        check("rst_rsp_err", rsp_err, 0);
        check("rst_bus_be", bus_be, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_wd", bus_wd, 0);
        rst_n = 1;
        @(negedge clk);

        // Reset while a beat is outstanding
        no_ack = 1; nbeats = 0;
        req_valid = 1; req_addr = 32'h10; req_we = 0; req_mode = 3'b010;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        check("mid_req_high", bus_req, 1);
        rst_n = 0;
        #1;
        check("mid_req_drop", bus_req, 0);
        check("mid_ready", req_ready, 1);
        @(negedge clk);
        rst_n = 1; no_ack = 0;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid) seen = 1;
        end
        check("mid_no_rsp", seen, 0);
        check("mid_ready_after", req_ready, 1);

        rdw[0] = 32'hDEADBEEF;
        run_op("lw", 32'h10, 0, 3'b010, 0, 0, 0, 2, 32'hDEADBEEF, 0);
        check("lw_beats", nbeats, 1);
        check("lw_addr", b_addr[0], 16'h0004);
        check("lw_be", b_be[0], 4'b1111);
        check("lw_we", b_we[0], 0);

        rdw[0] = 32'h80FF_0000;
        run_op("lb", 32'h13, 0, 3'b000, 0, 0, 0, 2, 32'hFFFF_FF80, 0);
        check("lb_be", b_be[0], 4'b1000);
        run_op("lbu", 32'h13, 0, 3'b100, 0, 0, 0, 2, 32'h0000_0080, 0);
        run_op("lh", 32'h12, 0, 3'b001, 0, 0, 0, 2, 32'hFFFF_80FF, 0);
        check("lh_be", b_be[0], 4'b1100);
        run_op("lhu", 32'h12, 0, 3'b101, 0, 0, 0, 2, 32'h0000_80FF, 0);

        run_op("sw_split", 32'h7, 1, 3'b010, 32'h1122_3344, 2, 0, 7, 32'h0, 0);
        check("sw_beats", nbeats, 2);
        check("sw_b1_addr", b_addr[0], 16'h0001);
        check("sw_b1_be", b_be[0], 4'b1000);
        check("sw_b1_wd", b_wd[0], 32'h4400_0000);
        check("sw_b1_we", b_we[0], 1);
        check("sw_b2_addr", b_addr[1], 16'h0002);
        check("sw_b2_be", b_be[1], 4'b0111);
        check("sw_b2_wd", b_wd[1], 32'h0011_2233);

        run_op("sh", 32'h21, 1, 3'b001, 32'h0000_A5B6, 1, 0, 3, 32'h0, 0);
        check("sh_beats", nbeats, 1);
        check("sh_addr", b_addr[0], 16'h0008);
        check("sh_be", b_be[0], 4'b0110);
        check("sh_wd", b_wd[0], 32'h00A5_B600);

        rdw[0] = 32'h3344_1111; rdw[1] = 32'h2222_1122;
        run_op("lw_split", 32'h102, 0, 3'b010, 0, 0, 0, 3, 32'h1122_3344, 0);
        check("lws_b1", {b_addr[0], 12'd0, b_be[0]}, {16'h0040, 12'd0, 4'b1100});
        check("lws_b2", {b_addr[1], 12'd0, b_be[1]}, {16'h0041, 12'd0, 4'b0011});

        run_op("tmo", 32'h20, 0, 3'b010, 0, 0, 1, 5, 32'h0, 1);
        check("tmo_req_cycles", req_cyc, 4);
        check("tmo_beats", nbeats, 0);

        run_op("bad_mode", 32'h0, 0, 3'b011, 0, 0, 0, 1, 32'h0, 1);
        check("bad_mode_noreq", req_cyc, 0);
        run_op("bad_addr", 32'h0004_0000, 0, 3'b010, 0, 0, 0, 1, 32'h0, 1);
        check("bad_addr_noreq", req_cyc, 0);
        run_op("bad_sbu", 32'h4, 1, 3'b100, 32'h55, 0, 0, 1, 32'h0, 1);
        check("bad_sbu_noreq", req_cyc, 0);

        rdw[0] = 32'hAB00_0000; rdw[1] = 32'h0000_00CD;
        run_op("lh_wrap", 32'h0003_FFFF, 0, 3'b001, 0, 0, 0, 3, 32'hFFFF_CDAB, 0);
        check("wrap_beats", nbeats, 2);
        check("wrap_b1_addr", b_addr[0], 16'hFFFF);
        check("wrap_b1_be", b_be[0], 4'b1000);
        check("wrap_b2_addr", b_addr[1], 16'h0000);
        check("wrap_b2_be", b_be[1], 4'b0001);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
